// File: rtl/mul_pkg.sv
// Shared types, widths and arithmetic helpers for the sequential multiply controller.
package mul_pkg;

  localparam int OP_W              = 32;
  localparam int RES_W             = 64;
  localparam int SETTLE_CYCLES_DEF = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_FIX  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  function automatic logic [OP_W-1:0] abs32(input logic is_signed, input logic [OP_W-1:0] v);
    logic [OP_W-1:0] r;
    if (is_signed && v[OP_W-1]) begin
      r = ~v + 32'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

  function automatic logic [RES_W-1:0] neg64(input logic [RES_W-1:0] v);
    return ~v + 64'd1;
  endfunction

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Issue, core and writeback signals of the multiply controller; slave is the controller's view.
interface mul_seq_ctrl_if;
  import mul_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [OP_W-1:0]  in_a;
  logic [OP_W-1:0]  in_b;
  logic             flush;
  logic [OP_W-1:0]  core_a;
  logic [OP_W-1:0]  core_b;
  logic [RES_W-1:0] core_p;
  logic             out_valid;
  logic             out_ready;
  logic [OP_W-1:0]  out_hi;
  logic [OP_W-1:0]  out_lo;

  modport slave (
    input  in_valid, in_signed, in_a, in_b, flush, core_p, out_ready,
    output in_ready, core_a, core_b, out_valid, out_hi, out_lo
  );

  modport master (
    output in_valid, in_signed, in_a, in_b, flush, core_p, out_ready,
    input  in_ready, core_a, core_b, out_valid, out_hi, out_lo
  );

endinterface

// File: rtl/mul_sign_fix.sv
// Operand magnitudes and result sign for a signed/unsigned multiply request.
module mul_sign_fix
  import mul_pkg::*;
(
  input  logic            i_signed,
  input  logic [OP_W-1:0] i_a,
  input  logic [OP_W-1:0] i_b,
  output logic [OP_W-1:0] o_abs_a,
  output logic [OP_W-1:0] o_abs_b,
  output logic            o_neg
);

  assign o_abs_a = abs32(i_signed, i_a);
  assign o_abs_b = abs32(i_signed, i_b);
  assign o_neg   = i_signed & (i_a[OP_W-1] ^ i_b[OP_W-1]);

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential control around an external combinational 32x32 multiplier core.
// Optional MUL_ZERO_BYPASS_EN: zero operands skip the core and complete on the accept edge.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
)
(
  input logic           clk,
  input logic           rst,
  mul_seq_ctrl_if.slave bus
);

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic             r_neg;
  logic [RES_W-1:0] r_prod;
  logic [OP_W-1:0]  r_core_a;
  logic [OP_W-1:0]  r_core_b;
  logic [OP_W-1:0]  r_out_hi;
  logic [OP_W-1:0]  r_out_lo;
  logic             r_out_valid;

  logic [OP_W-1:0]  w_abs_a;
  logic [OP_W-1:0]  w_abs_b;
  logic             w_neg;

  mul_sign_fix u_sign_fix (
    .i_signed (bus.in_signed),
    .i_a      (bus.in_a),
    .i_b      (bus.in_b),
    .o_abs_a  (w_abs_a),
    .o_abs_b  (w_abs_b),
    .o_neg    (w_neg)
  );

`ifdef MUL_ZERO_BYPASS_EN
  logic w_zero;
  assign w_zero = (bus.in_a == 32'd0) || (bus.in_b == 32'd0);
`endif

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.core_a    = r_core_a;
  assign bus.core_b    = r_core_b;
  assign bus.out_valid = r_out_valid;
  assign bus.out_hi    = r_out_hi;
  assign bus.out_lo    = r_out_lo;

  // Flush wins over both accept and out_ready; result registers keep their last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_neg       <= 1'b0;
      r_prod      <= 64'd0;
      r_core_a    <= 32'd0;
      r_core_b    <= 32'd0;
      r_out_hi    <= 32'd0;
      r_out_lo    <= 32'd0;
      r_out_valid <= 1'b0;
    end else if (bus.flush) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_core_a <= w_abs_a;
            r_core_b <= w_abs_b;
            r_neg    <= w_neg;
            r_cnt    <= CNT_INIT;
`ifdef MUL_ZERO_BYPASS_EN
            if (w_zero) begin
              r_out_hi    <= 32'd0;
              r_out_lo    <= 32'd0;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_state <= ST_WAIT;
            end
`else
            r_state <= ST_WAIT;
`endif
          end
        end
        ST_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_prod  <= bus.core_p;
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          {r_out_hi, r_out_lo} <= r_neg ? neg64(r_prod) : r_prod;
          r_out_valid          <= 1'b1;
          r_state              <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
